jt12_acc_ctrl: RTL and testbench
================================

JT12_ACC_CTRL -- requirements
Module: jt12_acc_ctrl

Interface
REQ-001 SHALL have parameter win, default 14, meaning operator/DAC sample width presented downstream.
REQ-002 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port clk_en  input  1  slot advance enable; state other than the register file advances only when high.
REQ-005 SHALL have port op_in  input  win  signed operator output for the current slot.
REQ-006 SHALL have port wr  input  1  register write strobe, sampled on clk regardless of clk_en.
REQ-007 SHALL have port wr_ch  input  3  target channel 0..5; values 6,7 ignored.
REQ-008 SHALL have port wr_alg  input  3  connection algorithm 0..7.
REQ-009 SHALL have port wr_pan  input  2  {left,right} enables.
REQ-010 SHALL have port dac_en  input  1  channel 5 replaced by DAC sample.
REQ-011 SHALL have port dac  input  8  unsigned DAC sample.
REQ-012 SHALL have port op_result  output  win  registered sample to accumulators.
REQ-013 SHALL have ports sum_en_l, sum_en_r  output  1 each  per-side accumulate enables.
REQ-014 SHALL have port zero  output  1  frame-start marker for accumulators.
REQ-015 SHALL have port slot  output  5  current slot index 0..23 (registered, aligned with op_result).

Function
REQ-016 SHALL keep a slot counter 0..23, +1 per clk_en cycle, 23 wraps to 0.
REQ-017 SHALL decode slot s as channel ch = s mod 6 and operator group g = s div 6, g order {S1,S3,S2,S4}.
REQ-018 SHALL hold per-channel alg (3b) and pan (2b) registers; write applies on the clk edge where wr=1 and wr_ch<=5.
REQ-019 SHALL use the pre-write value for a slot decoded in the same cycle as a write to its channel; new value from the next cycle.
REQ-020 SHALL mark carriers: alg0-3 S4; alg4 S2,S4; alg5-6 S2,S3,S4; alg7 S1,S2,S3,S4.
REQ-021 SHALL compute sum_en_l = carrier & pan[1], sum_en_r = carrier & pan[0] for the decoded slot.
REQ-022 SHALL, when dac_en=1 and ch=5: force sum_en_l/r to 0 except group S4, where carrier test is bypassed (pan still applies) and op_result = {~dac[7], dac[6:0], (win-8) zeros}.
REQ-023 SHALL otherwise pass op_in to op_result unchanged.
REQ-024 SHALL assert zero for exactly the one clk_en cycle in which registered slot = 0.
REQ-025 SHALL register op_result, sum_en_l, sum_en_r, zero, slot together on clk_en: latency one clk_en cycle from op_in/slot decode.
REQ-026 SHALL hold all outputs stable while clk_en=0.
REQ-027 SHALL sample dac_en and dac at the slot 5-S4 (s=23) decode cycle only; changes elsewhere have no effect until then.

Reset
REQ-028 SHALL, while rst=1, force slot counter 0, alg all 0, pan all 2'b11, op_result 0, sum_en_l/r 0, zero 0, slot 0.
REQ-029 SHALL, on rst release mid-frame, restart at slot 0 with first zero pulse on the first clk_en output cycle.
REQ-030 SHALL ignore wr while rst=1.

Structure
REQ-031 SHALL place slot count (24), group encoding and the carrier table in shared package jt12_pkg.
REQ-032 SHALL implement the algorithm-to-carrier decode as combinational sub-module jt12_carrier_dec (inputs alg, g; output carrier).
REQ-033 SHALL keep register file, counter and output pipeline in jt12_acc_ctrl.

Verification
REQ-034 SHALL test reset: rst pulse mid-frame -> all outputs 0, next outputs slot=0, zero=1, then slot 1..23 with zero=0.
REQ-035 SHALL test carriers: ch2 alg4 pan 11 -> sum_en_l=sum_en_r=1 only at slots 14 (S2) and 20 (S4) among ch2 slots.
REQ-036 SHALL test pan: ch0 alg7 pan 10 -> sum_en_l=1, sum_en_r=0 at slots 0,6,12,18.
REQ-037 SHALL test DAC: dac_en=1, dac=8'h80, win=14 -> slot 23 op_result=14'h0000 enabled; dac=8'hFF -> 14'h1FC0; slots 5,11,17 disabled.
REQ-038 SHALL test write collision: write ch3 alg0->alg7 in decode cycle of slot 3 -> slot 3 disabled, slot 9 enabled.
REQ-039 SHALL test clk_en gating: clk_en low 10 cycles -> outputs and slot frozen, resume at next index.

Source files
------------

// File: rtl/jt12_pkg.sv
// Shared slot, operator-group and carrier definitions for the JT12 accumulator control.
// Also provides the slot-to-channel/group decode helpers.
package jt12_pkg;

  localparam int unsigned NUM_SLOTS = 24;
  localparam int unsigned NUM_CH    = 6;
  localparam int unsigned SLOT_W    = 5;
  localparam int unsigned CH_W      = 3;
  localparam int unsigned ALG_W     = 3;
  localparam int unsigned PAN_W     = 2;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [CH_W-1:0]   DAC_CH    = CH_W'(NUM_CH - 1);

  // Operator groups in slot order: slots 0-5 S1, 6-11 S3, 12-17 S2, 18-23 S4.
  typedef enum logic [1:0] {
    GRP_S1 = 2'd0,
    GRP_S3 = 2'd1,
    GRP_S2 = 2'd2,
    GRP_S4 = 2'd3
  } grp_e;

  // Carrier mask per algorithm, one bit per grp_e encoding (bit3=S4, bit2=S2, bit1=S3, bit0=S1).
  localparam logic [7:0][3:0] CARRIER_TBL = {
    4'b1111,  // alg7
    4'b1110,  // alg6
    4'b1110,  // alg5
    4'b1100,  // alg4
    4'b1000,  // alg3
    4'b1000,  // alg2
    4'b1000,  // alg1
    4'b1000   // alg0
  };

  function automatic grp_e slot_grp(input logic [SLOT_W-1:0] s);
    if (s >= 5'd18)      return GRP_S4;
    else if (s >= 5'd12) return GRP_S2;
    else if (s >= 5'd6)  return GRP_S3;
    else                 return GRP_S1;
  endfunction

  function automatic logic [CH_W-1:0] slot_ch(input logic [SLOT_W-1:0] s);
    if (s >= 5'd18)      return CH_W'(s - 5'd18);
    else if (s >= 5'd12) return CH_W'(s - 5'd12);
    else if (s >= 5'd6)  return CH_W'(s - 5'd6);
    else                 return CH_W'(s);
  endfunction

endpackage

// File: rtl/jt12_carrier_dec.sv
// Combinational algorithm-to-carrier decode: is operator group g a carrier under alg?
module jt12_carrier_dec
  import jt12_pkg::*;
(
  input  logic [ALG_W-1:0] alg,
  input  grp_e             g,
  output logic             carrier
);

  assign carrier = CARRIER_TBL[alg][2'(g)];

endmodule

// File: rtl/jt12_acc_ctrl.sv
// Per-slot accumulator control: slot counter, channel alg/pan register file,
// carrier/pan gating, DAC substitution on channel 5 and the registered output stage.
module jt12_acc_ctrl
  import jt12_pkg::*;
#(
  parameter int unsigned win = 14
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   clk_en,
  input  logic [win-1:0]         op_in,
  input  logic                   wr,
  input  logic [2:0]             wr_ch,
  input  logic [2:0]             wr_alg,
  input  logic [1:0]             wr_pan,
  input  logic                   dac_en,
  input  logic [7:0]             dac,
  output logic [win-1:0]         op_result,
  output logic                   sum_en_l,
  output logic                   sum_en_r,
  output logic                   zero,
  output logic [4:0]             slot
);

  localparam int unsigned PAD_W = win - 8;

  logic [ALG_W-1:0]  alg_q [NUM_CH];
  logic [PAN_W-1:0]  pan_q [NUM_CH];
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic              dac_en_q, dac_en_d;

  logic [win-1:0]    op_result_q, op_result_d;
  logic              sum_en_l_q, sum_en_l_d;
  logic              sum_en_r_q, sum_en_r_d;
  logic              zero_q, zero_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  grp_e              grp;
  logic [CH_W-1:0]   ch;
  logic [ALG_W-1:0]  alg_cur;
  logic [PAN_W-1:0]  pan_cur;
  logic              carrier;
  logic              dac_sel;

  // Register file is clocked every cycle; a decode in the write cycle sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alg_q <= '{default: '0};
      pan_q <= '{default: 2'b11};
    end else if (wr && (wr_ch <= DAC_CH)) begin
      alg_q[wr_ch] <= wr_alg;
      pan_q[wr_ch] <= wr_pan;
    end
  end

  assign grp     = slot_grp(slot_cnt_q);
  assign ch      = slot_ch(slot_cnt_q);
  assign alg_cur = alg_q[ch];
  assign pan_cur = pan_q[ch];

  jt12_carrier_dec u_carrier_dec (
    .alg     (alg_cur),
    .g       (grp),
    .carrier (carrier)
  );

  // DAC enable is live only at the frame's last slot and held for the next frame.
  always_comb begin
    slot_cnt_d  = (slot_cnt_q == LAST_SLOT) ? '0 : slot_cnt_q + 5'd1;
    dac_en_d    = dac_en_q;
    dac_sel     = 1'b0;
    op_result_d = op_in;
    sum_en_l_d  = carrier & pan_cur[1];
    sum_en_r_d  = carrier & pan_cur[0];
    zero_d      = (slot_cnt_q == '0);
    slot_d      = slot_cnt_q;

    if (slot_cnt_q == LAST_SLOT) begin
      dac_en_d = dac_en;
      dac_sel  = dac_en;
    end else if (ch == DAC_CH) begin
      dac_sel  = dac_en_q;
    end

    if (dac_sel) begin
      if (grp == GRP_S4) begin
        sum_en_l_d  = pan_cur[1];
        sum_en_r_d  = pan_cur[0];
        op_result_d = {~dac[7], dac[6:0], {PAD_W{1'b0}}};
      end else begin
        sum_en_l_d  = 1'b0;
        sum_en_r_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      dac_en_q    <= 1'b0;
      op_result_q <= '0;
      sum_en_l_q  <= 1'b0;
      sum_en_r_q  <= 1'b0;
      zero_q      <= 1'b0;
      slot_q      <= '0;
    end else if (clk_en) begin
      slot_cnt_q  <= slot_cnt_d;
      dac_en_q    <= dac_en_d;
      op_result_q <= op_result_d;
      sum_en_l_q  <= sum_en_l_d;
      sum_en_r_q  <= sum_en_r_d;
      zero_q      <= zero_d;
      slot_q      <= slot_d;
    end
  end

  assign op_result = op_result_q;
  assign sum_en_l  = sum_en_l_q;
  assign sum_en_r  = sum_en_r_q;
  assign zero      = zero_q;
  assign slot      = slot_q;

endmodule

// File: tb/tb_jt12_acc_ctrl.sv
// Scoreboard bench for jt12_acc_ctrl: directed stimulus pushes expected outputs,
// an independent monitor pops and compares after every clock edge.
module tb_jt12_acc_ctrl;

  localparam int unsigned WIN = 14;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clk_en = 1'b0;
  logic [WIN-1:0] op_in = '0;
  logic           wr = 1'b0;
  logic [2:0]     wr_ch = '0;
  logic [2:0]     wr_alg = '0;
  logic [1:0]     wr_pan = '0;
  logic           dac_en = 1'b0;
  logic [7:0]     dac = '0;
  logic [WIN-1:0] op_result;
  logic           sum_en_l, sum_en_r, zero;
  logic [4:0]     slot;

  jt12_acc_ctrl #(.win(WIN)) dut (
    .rst       (rst),
    .clk       (clk),
    .clk_en    (clk_en),
    .op_in     (op_in),
    .wr        (wr),
    .wr_ch     (wr_ch),
    .wr_alg    (wr_alg),
    .wr_pan    (wr_pan),
    .dac_en    (dac_en),
    .dac       (dac),
    .op_result (op_result),
    .sum_en_l  (sum_en_l),
    .sum_en_r  (sum_en_r),
    .zero      (zero),
    .slot      (slot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]     slot;
    logic           zero;
    logic           l;
    logic           r;
    logic [WIN-1:0] op;
  } exp_t;

  exp_t expq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  int         m_slot;
  logic [2:0] m_alg [6];
  logic [1:0] m_pan [6];
  logic       m_dac_q;
  logic       nx_dac_en = 1'b0;
  logic [7:0] nx_dac    = 8'h00;

  // Group index g = s/6 runs S1, S3, S2, S4.
  function automatic logic is_carrier(input logic [2:0] alg, input int s);
    int g;
    g = s / 6;
    case (alg)
      3'd4:       return (g == 2) || (g == 3);
      3'd5, 3'd6: return g != 0;
      3'd7:       return 1'b1;
      default:    return g == 3;
    endcase
  endfunction

  task automatic model_reset();
    m_slot  = 0;
    m_dac_q = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_alg[i] = 3'd0;
      m_pan[i] = 2'b11;
    end
  endtask

  task automatic drive(input logic en, input logic w, input logic [2:0] wch,
                       input logic [2:0] walg, input logic [1:0] wpan);
    exp_t e;
    int   ch;
    logic car, deff;
    @(negedge clk);
    cyc++;
    clk_en = en;
    wr     = w;
    wr_ch  = wch;
    wr_alg = walg;
    wr_pan = wpan;
    dac_en = nx_dac_en;
    dac    = nx_dac;
    op_in  = WIN'(m_slot * 613 + cyc * 29 + 97);
    if (en) begin
      ch     = m_slot % 6;
      deff   = (m_slot == 23) ? nx_dac_en : m_dac_q;
      car    = is_carrier(m_alg[ch], m_slot);
      e.slot = 5'(m_slot);
      e.zero = (m_slot == 0);
      e.op   = op_in;
      e.l    = car & m_pan[ch][1];
      e.r    = car & m_pan[ch][0];
      if (ch == 5 && deff) begin
        if (m_slot == 23) begin
          e.l  = m_pan[5][1];
          e.r  = m_pan[5][0];
          e.op = {~nx_dac[7], nx_dac[6:0], 6'b000000};
        end else begin
          e.l = 1'b0;
          e.r = 1'b0;
        end
      end
      expq.push_back(e);
      if (m_slot == 23) m_dac_q = nx_dac_en;
      m_slot = (m_slot + 1) % 24;
    end
    if (w && wch <= 3'd5) begin
      m_alg[wch] = walg;
      m_pan[wch] = wpan;
    end
  endtask

  task automatic step(input logic en);
    drive(en, 1'b0, 3'd0, 3'd0, 2'b00);
  endtask

  task automatic step_wr(input logic en, input logic [2:0] wch,
                         input logic [2:0] walg, input logic [1:0] wpan);
    drive(en, 1'b1, wch, walg, wpan);
  endtask

  // Reset with a write attempt held across it; the write must be dropped.
  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    clk_en = 1'b1;
    wr     = 1'b1;
    wr_ch  = 3'd0;
    wr_alg = 3'd5;
    wr_pan = 2'b01;
    model_reset();
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    wr     = 1'b0;
    clk_en = 1'b0;
  endtask

  // Monitor: new expectation on each enabled edge, held value otherwise, zeros in reset.
  exp_t cur = '0;
  exp_t act;
  logic mon_en, mon_rst;
  always @(posedge clk) begin
    mon_en  = clk_en;
    mon_rst = rst;
    #1;
    if (mon_rst) begin
      cur = '0;
    end else if (mon_en) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow t=%0t: output produced with no expectation queued", $time);
      end else begin
        cur = expq.pop_front();
      end
    end
    act = {slot, zero, sum_en_l, sum_en_r, op_result};
    n_cmp++;
    if (act !== cur) begin
      n_fail++;
      $display("FAIL outputs t=%0t: got slot=%0d zero=%b l=%b r=%b op=%h, want slot=%0d zero=%b l=%b r=%b op=%h",
               $time, act.slot, act.zero, act.l, act.r, act.op,
               cur.slot, cur.zero, cur.l, cur.r, cur.op);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Default config: only S4 slots accumulate, both sides.
    repeat (30) step(1'b1);

    // Mid-frame reset, restart at slot 0 with zero pulse.
    do_reset();
    repeat (26) step(1'b1);

    // ch2 alg4 pan 11 (S2,S4 carriers); ch0 alg7 pan 10 (left only).
    while (m_slot != 1) step(1'b1);
    step_wr(1'b1, 3'd2, 3'd4, 2'b11);
    step_wr(1'b1, 3'd0, 3'd7, 2'b10);
    step_wr(1'b1, 3'd6, 3'd7, 2'b00);
    repeat (26) step(1'b1);

    // Write collision on ch3 during slot 3 decode.
    while (m_slot != 3) step(1'b1);
    step_wr(1'b1, 3'd3, 3'd7, 2'b11);
    repeat (8) step(1'b1);

    // clk_en gating with a write landing while frozen.
    repeat (5) step(1'b0);
    step_wr(1'b0, 3'd4, 3'd5, 2'b01);
    repeat (4) step(1'b0);
    repeat (30) step(1'b1);

    // DAC on channel 5: enable mid-frame, takes effect from slot 23.
    while (m_slot != 8) step(1'b1);
    nx_dac_en = 1'b1;
    nx_dac    = 8'h80;
    repeat (40) step(1'b1);
    nx_dac = 8'hFF;
    repeat (24) step(1'b1);
    while (m_slot != 10) step(1'b1);
    nx_dac_en = 1'b0;
    nx_dac    = 8'h3C;
    repeat (40) step(1'b1);

    step(1'b0);
    step(1'b0);
    @(negedge clk);
    n_cmp++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
